// File: rtl/grid_cursor_ctrl_pkg.sv
// rtl/grid_cursor_ctrl_pkg.sv - shared types for the grid cursor controller
package grid_cursor_ctrl_pkg;

  typedef enum logic [1:0] {
    AX_IDLE   = 2'd0,
    AX_DELAY  = 2'd1,
    AX_REPEAT = 2'd2
  } axis_state_t;

endpackage

// File: rtl/grid_cursor_ctrl_axis_repeat.sv
// rtl/grid_cursor_ctrl_axis_repeat.sv - per-axis press / auto-repeat step generator
module grid_cursor_ctrl_axis_repeat
  import grid_cursor_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 30_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic neg,
  input  logic pos,
  input  logic lock,
  output logic step_inc,
  output logic step_dec
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE - 1);

  axis_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             held_inc, held_inc_next;
  logic             dir_inc, dir_dec, active, same, step;

  assign dir_inc = pos & ~neg;
  assign dir_dec = neg & ~pos;
  assign active  = (dir_inc | dir_dec) & ~lock;
  // Holding continues only while the originally pressed direction persists.
  assign same    = active & (dir_inc == held_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= AX_IDLE;
      cnt      <= '0;
      held_inc <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      held_inc <= held_inc_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    held_inc_next = held_inc;
    step          = 1'b0;
    case (state)
      AX_IDLE: begin
        if (active) begin
          step          = 1'b1;
          held_inc_next = dir_inc;
          state_next    = AX_DELAY;
          cnt_next      = '0;
        end
      end
      AX_DELAY: begin
        if (!same) begin
          state_next = AX_IDLE;
          cnt_next   = '0;
        end else if (cnt == DELAY_END) begin
          step       = 1'b1;
          state_next = AX_REPEAT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      AX_REPEAT: begin
        if (!same) begin
          state_next = AX_IDLE;
          cnt_next   = '0;
        end else if (cnt == RATE_END) begin
          step     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = AX_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign step_inc = step & held_inc_next;
  assign step_dec = step & ~held_inc_next;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// rtl/grid_cursor_ctrl.sv - bounded 2-D cursor with auto-repeat stepping and following viewport
module grid_cursor_ctrl
  import grid_cursor_ctrl_pkg::*;
#(
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int COORD_W      = 5,
  parameter int RESET_X      = 7,
  parameter int RESET_Y      = 7,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 30_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int VIEW_W       = 8,
  parameter int VIEW_H       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               lock,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [COORD_W-1:0] view_x,
  output logic [COORD_W-1:0] view_y,
  output logic               moved
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] VW_M1   = COORD_W'(VIEW_W - 1);
  localparam logic [COORD_W-1:0] VH_M1   = COORD_W'(VIEW_H - 1);
  localparam int                 RST_VX  = (RESET_X < VIEW_W) ? 0 : RESET_X - VIEW_W + 1;
  localparam int                 RST_VY  = (RESET_Y < VIEW_H) ? 0 : RESET_Y - VIEW_H + 1;

  logic               x_inc, x_dec, y_inc, y_dec;
  logic [COORD_W-1:0] nx, ny;
  logic               changed_q;

  grid_cursor_ctrl_axis_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .neg     (left),
    .pos     (right),
    .lock    (lock),
    .step_inc(x_inc),
    .step_dec(x_dec)
  );

  grid_cursor_ctrl_axis_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .neg     (up),
    .pos     (down),
    .lock    (lock),
    .step_inc(y_inc),
    .step_dec(y_dec)
  );

  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic inc, input logic dec,
                                                    input logic [COORD_W-1:0] maxv);
    logic [COORD_W-1:0] r;
    r = c;
    if (inc) begin
      if (c == maxv) r = (WRAP != 0) ? '0 : c;
      else           r = c + COORD_W'(1);
    end else if (dec) begin
      if (c == '0) r = (WRAP != 0) ? maxv : c;
      else         r = c - COORD_W'(1);
    end
    return r;
  endfunction

  // Widened compare keeps the right/bottom viewport edge from aliasing.
  function automatic logic [COORD_W-1:0] view_follow(input logic [COORD_W-1:0] c,
                                                     input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] span_m1);
    logic [COORD_W:0] last;
    last = {1'b0, v} + {1'b0, span_m1};
    if (c < v)                 return c;
    else if ({1'b0, c} > last) return c - span_m1;
    else                       return v;
  endfunction

  assign nx = step_coord(cur_x, x_inc, x_dec, X_MAX);
  assign ny = step_coord(cur_y, y_inc, y_dec, Y_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x     <= COORD_W'(RESET_X);
      cur_y     <= COORD_W'(RESET_Y);
      view_x    <= COORD_W'(RST_VX);
      view_y    <= COORD_W'(RST_VY);
      changed_q <= 1'b0;
      moved     <= 1'b0;
    end else begin
      cur_x     <= nx;
      cur_y     <= ny;
      view_x    <= view_follow(cur_x, view_x, VW_M1);
      view_y    <= view_follow(cur_y, view_y, VH_M1);
      changed_q <= (nx != cur_x) | (ny != cur_y);
      moved     <= changed_q;
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb/tb_grid_cursor_ctrl.sv - randomized and directed bench with reference model for grid_cursor_ctrl
module tb_grid_cursor_ctrl;

  localparam int GW = 20, GH = 15, CW = 5, RX = 7, RY = 7;
  localparam int RD = 4, RR = 2, VW = 8, VH = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, lock = 1'b0;
  logic [CW-1:0] cx0, cy0, vx0, vy0, cx1, cy1, vx1, vy1;
  logic mv0, mv1;

  int total = 0;
  int bad = 0;

  int mx[2], my[2], mvx[2], mvy[2], mmv[2], mpend[2];
  int hx, kx, hy, ky;

  grid_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .RESET_X(RX), .RESET_Y(RY),
    .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .VIEW_W(VW), .VIEW_H(VH)) dut0 (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right), .lock(lock),
    .cur_x(cx0), .cur_y(cy0), .view_x(vx0), .view_y(vy0), .moved(mv0));

  grid_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .RESET_X(RX), .RESET_Y(RY),
    .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .VIEW_W(VW), .VIEW_H(VH)) dut1 (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right), .lock(lock),
    .cur_x(cx1), .cur_y(cy1), .view_x(vx1), .view_y(vy1), .moved(mv1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int axis_dir(input logic neg, input logic pos);
    if (pos && !neg) return 1;
    if (neg && !pos) return -1;
    return 0;
  endfunction

  // Steps fall at hold ages 0, RD, RD+RR, RD+2*RR, ...
  task automatic axis_model(input int dir, inout int h, inout int k, output int st);
    st = 0;
    if (dir == 0) h = 0;
    else if (h == 0) begin h = dir; k = 0; st = dir; end
    else if (dir != h) h = 0;
    else begin
      k++;
      if (k == RD || (k > RD && (k - RD) % RR == 0)) st = dir;
    end
  endtask

  function automatic int move(input int c, input int s, input int n, input int wrap);
    int t;
    t = c + s;
    if (t < 0)  return wrap ? n - 1 : 0;
    if (t >= n) return wrap ? 0 : n - 1;
    return t;
  endfunction

  function automatic int follow(input int c, input int v, input int span);
    if (c < v) return c;
    if (c > v + span - 1) return c - span + 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mx[w] = RX; my[w] = RY;
      mvx[w] = (RX < VW) ? 0 : RX - VW + 1;
      mvy[w] = (RY < VH) ? 0 : RY - VH + 1;
      mmv[w] = 0; mpend[w] = 0;
    end
    hx = 0; kx = 0; hy = 0; ky = 0;
  endtask

  task automatic model_edge();
    int sx, sy, nx, ny;
    if (!rst) begin model_reset(); return; end
    axis_model(lock ? 0 : axis_dir(left, right), hx, kx, sx);
    axis_model(lock ? 0 : axis_dir(up, down), hy, ky, sy);
    for (int w = 0; w < 2; w++) begin
      mvx[w] = follow(mx[w], mvx[w], VW);
      mvy[w] = follow(my[w], mvy[w], VH);
      mmv[w] = mpend[w];
      nx = move(mx[w], sx, GW, w);
      ny = move(my[w], sy, GH, w);
      mpend[w] = (nx != mx[w] || ny != my[w]) ? 1 : 0;
      mx[w] = nx; my[w] = ny;
    end
  endtask

  task automatic check_all();
    check("w0.cur_x", cx0, mx[0]);  check("w0.cur_y", cy0, my[0]);
    check("w0.view_x", vx0, mvx[0]); check("w0.view_y", vy0, mvy[0]);
    check("w0.moved", mv0, mmv[0]);
    check("w1.cur_x", cx1, mx[1]);  check("w1.cur_y", cy1, my[1]);
    check("w1.view_x", vx1, mvx[1]); check("w1.view_y", vy1, mvy[1]);
    check("w1.moved", mv1, mmv[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic u, input logic d, input logic l, input logic r, input logic lk);
    up = u; down = d; left = l; right = r; lock = lk;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int remain;
    int pat;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst.cur_x", cx0, 7); check("rst.cur_y", cy0, 7);
    check("rst.view_x", vx0, 0); check("rst.view_y", vy0, 2);
    check("rst.moved", mv0, 0);
    check_all();

    // single-cycle press
    set_in(0, 0, 0, 1, 0); tick();
    check("pulse.cur_x", cx0, 8); check("pulse.view_x_hold", vx0, 0);
    set_in(0, 0, 0, 0, 0); tick();
    check("pulse.moved", mv0, 1); check("pulse.view_x", vx0, 1);
    tick();
    check("pulse.moved_off", mv0, 0);

    // held press: steps at edges 0,4,6,8
    do_reset();
    set_in(0, 0, 0, 1, 0);
    repeat (10) tick();
    check("hold.cur_x", cx0, 11); check("hold.view_x", vx0, 4);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async.cur_x", cx0, 7); check("async.cur_y", cy0, 7);
    check("async.view_x", vx0, 0); check("async.view_y", vy0, 2);
    check("async.moved", mv0, 0);
    set_in(0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    // left edge: saturate vs wrap
    set_in(0, 0, 1, 0, 0);
    repeat (15) tick();
    check("edge.w0_x", cx0, 0); check("edge.w1_x", cx1, 0);
    set_in(0, 0, 0, 0, 0); repeat (3) tick();
    set_in(0, 0, 1, 0, 0); tick();
    check("sat.cur_x", cx0, 0); check("wrap.cur_x", cx1, 19);
    set_in(0, 0, 0, 0, 0); tick();
    check("sat.moved", mv0, 0); check("wrap.moved", mv1, 1); check("wrap.view_x", vx1, 12);

    // opposing directions, then diagonal
    do_reset();
    set_in(1, 1, 0, 0, 0);
    repeat (20) tick();
    check("both.cur_y", cy0, 7);
    set_in(0, 1, 0, 1, 0); tick();
    check("diag.cur_x", cx0, 8); check("diag.cur_y", cy0, 8);
    set_in(0, 0, 0, 0, 0); tick();
    check("diag.moved", mv0, 1);
    tick();
    check("diag.moved_once", mv0, 0);

    // lock mid-hold
    do_reset();
    set_in(0, 1, 0, 0, 0);
    repeat (2) tick();
    set_in(0, 1, 0, 0, 1);
    repeat (7) tick();
    check("lock.cur_y", cy0, 8);
    set_in(0, 1, 0, 0, 0); tick();
    check("unlock.cur_y", cy0, 9);

    // randomized phase
    do_reset();
    remain = 0;
    for (int i = 0; i < 3000; i++) begin
      if (remain == 0) begin
        pat = $urandom % 16;
        set_in(pat[0], pat[1], pat[2], pat[3], ($urandom % 8) == 0);
        remain = $urandom_range(1, 24);
      end
      remain--;
      if ($urandom % 400 == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
